// File: rtl/midi_serializer.sv
// MIDI 8N1 UART transmitter with a small byte FIFO in front of the line FSM.
// Define MIDI_RUNNING_STATUS_EN to drop repeated channel-voice status bytes at pop.
module midi_serializer #(
  parameter int CLK_HZ     = 50_000_000,
  parameter int BAUD       = 31250,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic [7:0]                  byte_in,
  input  logic                        byte_valid,
  output logic                        byte_ready,
  output logic                        tx,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  localparam int CPB = CLK_HZ / BAUD;
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int BW  = $clog2(CPB);

  localparam logic [BW-1:0] BAUD_LAST = BW'(CPB - 1);
  localparam logic [AW:0]   DEPTH_C   = (AW + 1)'(FIFO_DEPTH);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;

  logic [1:0]    state;
  logic [BW-1:0] baud_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift;

  logic          push;
  logic          pop;
  logic          drop;
  logic          send;
  logic          baud_end;
  logic [7:0]    head;

  assign head       = mem[rd_ptr];
  assign byte_ready = count < DEPTH_C;
  assign push       = byte_valid && byte_ready;
  assign baud_end   = baud_cnt == BAUD_LAST;
  assign pop        = (count != '0) &&
                      ((state == IDLE) ||
                       (state == STOP && baud_end));
  assign send       = pop && !drop;
  assign busy       = (state != IDLE) || (count != '0);
  assign fifo_count = count;

`ifdef MIDI_RUNNING_STATUS_EN
  logic [7:0] last_status;
  logic       last_valid;
  logic       is_voice;

  assign is_voice = head[7] && (head[7:4] != 4'hF);
  assign drop     = is_voice && last_valid &&
                    (head == last_status);

  // System common / SysEx cancels running status; real-time and data keep it.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      last_status <= 8'h00;
      last_valid  <= 1'b0;
    end else if (send) begin
      if (is_voice) begin
        last_status <= head;
        last_valid  <= 1'b1;
      end else if (head[7:3] == 5'b11110) begin
        last_valid  <= 1'b0;
      end
    end
  end
`else
  assign drop = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= byte_in;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      count <= count + (AW + 1)'(1);
      else if (pop && !push) count <= count - (AW + 1)'(1);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
      tx       <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          tx       <= 1'b1;
          baud_cnt <= '0;
          if (send) begin
            shift <= head;
            state <= START;
            tx    <= 1'b0;
          end
        end
        START: begin
          if (baud_end) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
            state    <= DATA;
            tx       <= shift[0];
          end else begin
            baud_cnt <= baud_cnt + BW'(1);
          end
        end
        DATA: begin
          if (baud_end) begin
            baud_cnt <= '0;
            if (bit_cnt == 3'd7) begin
              state <= STOP;
              tx    <= 1'b1;
            end else begin
              shift   <= shift >> 1;
              tx      <= shift[1];
              bit_cnt <= bit_cnt + 3'd1;
            end
          end else begin
            baud_cnt <= baud_cnt + BW'(1);
          end
        end
        STOP: begin
          if (baud_end) begin
            baud_cnt <= '0;
            // Next queued byte starts immediately, keeping frames contiguous.
            if (send) begin
              shift <= head;
              state <= START;
              tx    <= 1'b0;
            end else begin
              state <= IDLE;
              tx    <= 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt + BW'(1);
          end
        end
        default: begin
          state <= IDLE;
          tx    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_midi_serializer.sv
// Bench for midi_serializer: frame-position model checked every cycle,
// plus hand-computed waveform points for a 0x90 frame and reset behaviour.
module tb_midi_serializer;

  localparam int BAUD   = 31250;
  localparam int CPB    = 16;
  localparam int CLK_HZ = BAUD * CPB;
  localparam int DEPTH  = 4;
  localparam int FRAME  = 10 * CPB;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] byte_in = 8'h00;
  logic       byte_valid = 1'b0;
  logic       byte_ready;
  logic       tx;
  logic       busy;
  logic [2:0] fifo_count;

  midi_serializer #(
    .CLK_HZ(CLK_HZ),
    .BAUD(BAUD),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .byte_in(byte_in),
    .byte_valid(byte_valid),
    .byte_ready(byte_ready),
    .tx(tx),
    .busy(busy),
    .fifo_count(fifo_count)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int passed = 0;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h want %0h at %0t",
                  name, act, exp, $time);
  endtask

  // Model: queue of buffered bytes and the position inside the frame on the line.
  logic [7:0] mq[$];
  bit         active = 0;
  int         pos = 0;
  logic [7:0] cur = 8'h00;
  logic [7:0] m_last = 8'h00;
  bit         m_last_v = 0;

  function automatic bit rs_drop(input logic [7:0] b);
`ifdef MIDI_RUNNING_STATUS_EN
    if (b >= 8'h80 && b <= 8'hEF) begin
      if (m_last_v && b == m_last) return 1'b1;
      m_last   = b;
      m_last_v = 1'b1;
    end else if (b >= 8'hF0 && b <= 8'hF7) begin
      m_last_v = 1'b0;
    end
`endif
    return b === 8'hxx;
  endfunction

  function automatic logic exp_tx();
    int idx;
    if (!active) return 1'b1;
    idx = pos / CPB;
    if (idx == 0) return 1'b0;
    if (idx == 9) return 1'b1;
    return cur[idx-1];
  endfunction

  task automatic model_step();
    bit do_push;
    logic [7:0] b;
    if (!reset_n) begin
      mq.delete();
      active   = 0;
      pos      = 0;
      m_last_v = 0;
    end else begin
      do_push = byte_valid && (mq.size() < DEPTH);
      if (active) begin
        pos++;
        if (pos == FRAME) active = 0;
      end
      if (!active && mq.size() > 0) begin
        b = mq.pop_front();
        if (!rs_drop(b)) begin
          cur    = b;
          active = 1;
          pos    = 0;
        end
      end
      if (do_push) mq.push_back(byte_in);
    end
  endtask

  initial forever begin
    @(posedge clock);
    model_step();
  end

  initial forever begin
    @(negedge clock);
    #1;
    if (!reset_n) begin
      check("rst_tx", tx, 1);
      check("rst_busy", busy, 0);
      check("rst_count", fifo_count, 0);
      check("rst_ready", byte_ready, 1);
    end else begin
      check("tx", tx, exp_tx());
      check("busy", busy, (active || mq.size() > 0));
      check("count", fifo_count, mq.size());
      check("ready", byte_ready, (mq.size() < DEPTH));
    end
  end

  logic [7:0] stim[$];
  bit saw_full = 0;

  task automatic push_stream();
    int i = 0;
    int budget = 0;
    while (i < stim.size() && budget < 100000) begin
      @(negedge clock);
      byte_valid = 1'b1;
      byte_in    = stim[i];
      if (byte_ready) i++;
      else saw_full = 1;
      budget++;
    end
    if (i < stim.size()) check("push_timeout", i, stim.size());
    @(negedge clock);
    byte_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((active || mq.size() > 0) && n < 5000) begin
      @(negedge clock);
      n++;
    end
    if (n >= 5000) check("drain_timeout", n, 0);
    @(negedge clock);
  endtask

  logic [9:0] frame90 = 10'b1100100000;

  initial begin
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    repeat (2) @(negedge clock);

    // Single 0x90 frame, sampled mid-bit by hand.
    byte_valid = 1'b1;
    byte_in    = 8'h90;
    @(negedge clock);
    byte_valid = 1'b0;
    #1;
    check("lat_tx_high", tx, 1);
    check("lat_count", fifo_count, 1);
    for (int i = 0; i < 10; i++) begin
      repeat ((i == 0) ? 9 : 16) @(negedge clock);
      #1;
      check($sformatf("bit%0d", i), tx, frame90[i]);
    end
    repeat (7) @(negedge clock);
    #1;
    check("busy_last", busy, 1);
    @(negedge clock);
    #1;
    check("busy_drop", busy, 0);
    wait_idle();

    // Three-byte message back to back.
    stim.delete();
    stim.push_back(8'h90);
    stim.push_back(8'h3C);
    stim.push_back(8'h7F);
    push_stream();
    #1;
    check("msg3_count", fifo_count, 2);
    wait_idle();

    // Six bytes held valid: FIFO fills and stalls.
    stim.delete();
    for (int i = 0; i < 6; i++) stim.push_back(8'(8'h40 + i));
    saw_full = 0;
    push_stream();
    check("saw_full", saw_full, 1);
    wait_idle();

    // Reset in the middle of a 0x55 data phase.
    stim.delete();
    stim.push_back(8'h55);
    push_stream();
    repeat (40) @(negedge clock);
    reset_n = 1'b0;
    #1;
    check("mid_rst_tx", tx, 1);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_count", fifo_count, 0);
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    stim.delete();
    stim.push_back(8'hA6);
    push_stream();
    wait_idle();

`ifdef MIDI_RUNNING_STATUS_EN
    stim.delete();
    stim.push_back(8'h90); stim.push_back(8'h3C); stim.push_back(8'h7F);
    stim.push_back(8'hF8);
    stim.push_back(8'h90); stim.push_back(8'h3E); stim.push_back(8'h7F);
    stim.push_back(8'hF2);
    stim.push_back(8'h90); stim.push_back(8'h40);
    push_stream();
    wait_idle();
`endif

    // Random sparse traffic.
    for (int n = 0; n < 3000; n++) begin
      @(negedge clock);
      byte_valid = ($urandom_range(0, 19) == 0);
      byte_in    = 8'($urandom);
    end
    @(negedge clock);
    byte_valid = 1'b0;
    wait_idle();

    // Every byte value, streamed.
    stim.delete();
    for (int i = 0; i < 256; i++) stim.push_back(8'(i));
    push_stream();
    wait_idle();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
